hazard_stall_ctrl: RTL and testbench

- Central stall/bubble controller for the 5-stage pipeline.
- Detects RAW hazards that forwarding cannot cover using Tuse/Tnew.
- Sequences the multi-cycle mult/div unit with a busy counter.
- Drives the `pause` inputs of F2D/PC and the bubble (reset) input of D2E.

---
 rtl/hazard_stall_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: Tuse/Tnew RAW detection plus mult/div busy sequencing.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic [4:0]  E_dst,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        stall,
  output logic        F_pause,
  output logic        E_bubble,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  // A producer blocks the consumer only when its value arrives later than it is needed.
  function automatic logic raw_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] dst,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (dst == src) && (tuse < tnew);
  endfunction

  always_comb begin
    stall_rs = raw_hazard(D_rs, D_rs_tuse, E_dst, E_tnew) |
               raw_hazard(D_rs, D_rs_tuse, M_dst, M_tnew);
    stall_rt = raw_hazard(D_rt, D_rt_tuse, E_dst, E_tnew) |
               raw_hazard(D_rt, D_rt_tuse, M_dst, M_tnew);
    stall_md = D_is_md & (md_busy | E_md_start);
    stall    = stall_rs | stall_rt | stall_md;
  end

  assign F_pause  = stall;
  assign E_bubble = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // E/M/W never stall, so the busy count keeps running while D is held.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (E_md_start) begin
          cnt_nxt   = E_md_is_div ? DIV_LD : MULT_LD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (cnt != '0);

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed spec scenarios plus randomized traffic
// compared against a remaining-cycles reference model.
module tb_hazard_stall_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_dst, M_dst;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_is_div;
  logic        stall, F_pause, E_bubble, md_busy;
  logic [31:0] stall_cnt;

  int          tests = 0;
  int          fails = 0;
  int          remain = 0;
  logic [31:0] m_cnt = 32'h0;

  hazard_stall_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_is_md(D_is_md), .E_dst(E_dst), .E_tnew(E_tnew), .M_dst(M_dst), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .stall(stall), .F_pause(F_pause), .E_bubble(E_bubble), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit needs_wait(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 5'd0) return 1'b0;
    return (E_dst == r && tuse < E_tnew) || (M_dst == r && tuse < M_tnew);
  endfunction

  function automatic bit exp_stall();
    bit md_wait;
    md_wait = D_is_md && (remain > 0 || E_md_start);
    return needs_wait(D_rs, D_rs_tuse) || needs_wait(D_rt, D_rt_tuse) || md_wait;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef HAZARD_STALL_CNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic set_idle();
    D_rs = 0; D_rt = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_is_md = 0;
    E_dst = 0; E_tnew = 0; M_dst = 0; M_tnew = 0; E_md_start = 0; E_md_is_div = 0;
  endtask

  // Advance one clock, updating the model with what the current inputs imply.
  task automatic advance();
    bit s;
    s = exp_stall();
    @(posedge clk);
    if (!reset) begin
      remain = 0;
      m_cnt  = 32'h0;
    end else begin
      if (s) m_cnt = m_cnt + 32'd1;
      if (remain > 0) remain = remain - 1;
      else if (E_md_start) remain = E_md_is_div ? DIV : MULT;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    #2;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
    tests++; if (stall_cnt !== 32'h0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    set_idle();
    E_dst = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall got %b want 1", stall); end
    tests++; if ({F_pause, E_bubble} !== 2'b11) begin fails++; $display("FAIL load_use_outs got %b want 11", {F_pause, E_bubble}); end
    advance();
    E_dst = 0; E_tnew = 0; M_dst = 8; M_tnew = 1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_use_release got %b want 0", stall); end
    advance();
  endtask

  task automatic test_zero_reg();
    set_idle();
    E_dst = 0; D_rs = 0; E_tnew = 2; D_rs_tuse = 0; M_dst = 0; M_tnew = 3;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL zero_reg got %b want 0", stall); end
    advance();
  endtask

  task automatic test_no_hazard();
    set_idle();
    E_dst = 8; E_tnew = 1; D_rt = 8; D_rt_tuse = 1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL no_hazard got %b want 0", stall); end
    M_dst = 8; M_tnew = 2;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL m_stage_hazard got %b want 1", stall); end
    advance();
  endtask

  task automatic test_mult();
    set_idle();
    E_md_start = 1; E_md_is_div = 0; D_is_md = 1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mult_c0_stall got %b want 1", stall); end
    advance();
    E_md_start = 0;
    for (int c = 1; c <= MULT; c++) begin
      #1;
      tests++; if (md_busy !== 1'b1) begin fails++; $display("FAIL mult_busy_c%0d got %b want 1", c, md_busy); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mult_stall_c%0d got %b want 1", c, stall); end
      advance();
    end
    #1;
    tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL mult_done_busy got %b want 0", md_busy); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mult_done_stall got %b want 0", stall); end
    advance();
  endtask

  task automatic test_div_reset();
    set_idle();
    E_md_start = 1; E_md_is_div = 1;
    advance();
    E_md_start = 0;
    for (int c = 0; c < 3; c++) advance();
    tests++; if (md_busy !== 1'b1) begin fails++; $display("FAIL div_busy_before_reset got %b want 1", md_busy); end
    #2 reset = 1'b0;
    #1;
    tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL div_async_reset got %b want 0", md_busy); end
    tests++; if (stall_cnt !== 32'h0) begin fails++; $display("FAIL div_reset_cnt got %0d want 0", stall_cnt); end
    advance();
    reset = 1'b1;
    D_is_md = 1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL div_after_reset_stall got %b want 0", stall); end
    advance();
    tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL div_after_reset_busy got %b want 0", md_busy); end
    set_idle();
  endtask

  task automatic test_stall_cnt();
    logic [31:0] want;
    set_idle();
    #1 reset = 1'b0;
    advance();
    reset = 1'b1;
    E_dst = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 1;
    for (int c = 0; c < 3; c++) advance();
    set_idle();
    E_md_start = 1; E_md_is_div = 1;
    advance();
    E_md_start = 0; D_is_md = 1;
    for (int c = 0; c < DIV; c++) advance();
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL cnt_div_release got %b want 0", stall); end
`ifdef HAZARD_STALL_CNT_EN
    want = 32'd13;
`else
    want = 32'd0;
`endif
    tests++; if (stall_cnt !== want) begin fails++; $display("FAIL stall_cnt_total got %0d want %0d", stall_cnt, want); end
    set_idle();
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      E_dst = 5'($urandom_range(0, 3)); M_dst = 5'($urandom_range(0, 3));
      D_rs_tuse = 2'($urandom); D_rt_tuse = 2'($urandom);
      E_tnew = 2'($urandom); M_tnew = 2'($urandom);
      D_is_md = ($urandom_range(0, 2) == 0);
      E_md_start = ($urandom_range(0, 7) == 0);
      E_md_is_div = 1'($urandom);
      #1;
      tests++; if (stall !== exp_stall()) begin fails++; $display("FAIL rand_stall c%0d got %b want %b", c, stall, exp_stall()); end
      tests++; if ({F_pause, E_bubble} !== {2{exp_stall()}}) begin fails++; $display("FAIL rand_outs c%0d got %b", c, {F_pause, E_bubble}); end
      tests++; if (md_busy !== (remain > 0)) begin fails++; $display("FAIL rand_busy c%0d got %b want %b", c, md_busy, remain > 0); end
      tests++; if (stall_cnt !== exp_cnt()) begin fails++; $display("FAIL rand_cnt c%0d got %0d want %0d", c, stall_cnt, exp_cnt()); end
      advance();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_no_hazard();
    test_mult();
    test_div_reset();
    test_random();
    test_stall_cnt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
